// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM state codes and ALU operation codes.
package main_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decoder: aluop from the FSM plus funct from the IR
// select the ALU operation.
module alu_dec
    import main_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Moore control FSM for the multicycle MIPS datapath; write enables are
// masked while reset is high so an aborted instruction never writes.
module main_fsm
    import main_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t     state_reg;
    state_t     state_next;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       memwrite_s;
    logic       illegal_s;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        illegal_s  = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                state_next = S_DECODE;
                alusrcb    = 2'b01;
                irwrite_s  = 1'b1;
                pcwrite    = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next = S_FETCH;
                        illegal_s  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
            end
            S_MEMRD: begin
                state_next = S_MEMWB;
                iord       = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                state_next = S_ALUWB;
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                state_next = S_ADDIWB;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Selects already sit at FETCH values in reset; only enables need masking.
    assign pcen       = ~reset & (pcwrite | (branch & zero));
    assign irwrite    = ~reset & irwrite_s;
    assign regwrite   = ~reset & regwrite_s;
    assign memwrite   = ~reset & memwrite_s;
    assign illegal_op = ~reset & illegal_s;
    assign state      = state_reg;

endmodule
